ps2_rx_fifo: RTL and testbench

// - PS/2 device-to-host serial receiver with an 8-byte receive FIFO.
// - Oversamples ps2_clk/ps2_dat on the system clock and assembles 11-bit frames into scan-code bytes.
// - Presents the bytes to a downstream scan-code decoder/FSM through a ready/read_next pop interface.
// - Sits between the board PS/2 pins and the keyboard decoder, which drives the seven-segment/LED logic.

---
 rtl/ps2_rx_fifo_if.sv | 12 +
 rtl/ps2_rx_fifo.sv | 109 ++++++++++
 tb/tb_ps2_rx_fifo.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: pop-side handshake between the PS/2 receive FIFO and the
// downstream scan-code decoder. The slave modport is the FIFO and the master
// modport is the consumer.
interface ps2_rx_fifo_if;
  logic       read_next;
  logic       ready;
  logic       overflow;
  logic [7:0] data;

  modport slave  (input  read_next, output ready, output overflow, output data);
  modport master (output read_next, input  ready, input  overflow, input  data);
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with a small receive FIFO.
//
// ps2_clk is oversampled on clk, and each falling edge becomes a one-cycle
// strobe. The design assembles 11-bit frames from these strobes. Valid bytes
// are pushed into a FIFO of 2**FIFO_AW entries, of which (2**FIFO_AW)-1 are
// usable.
//
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames with bad odd
// parity. Without it, only the start and stop bits are checked.
module ps2_rx_fifo #(
  parameter int FIFO_AW = 3
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           ps2_clk,
  input  logic           ps2_dat,
  ps2_rx_fifo_if.slave   bus
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [2:0]         clk_sync_q, clk_sync_d;
  logic [1:0]         dat_sync_q, dat_sync_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [9:0]         buffer_q, buffer_d;
  logic [FIFO_AW-1:0] w_ptr_q, w_ptr_d;
  logic [FIFO_AW-1:0] r_ptr_q, r_ptr_d;
  logic               ready_q, ready_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         fifo_q [DEPTH];

  logic strobe;
  logic frame_ok;
  logic accept;
  logic full;
  logic wr_en;
  logic pop;

  // Frame decode, FIFO pointer and flag next-state logic.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    clk_sync_d = {clk_sync_q[1:0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_dat};
    cnt_d      = cnt_q;
    buffer_d   = buffer_q;

    strobe   = clk_sync_q[2] & ~clk_sync_q[1];
`ifdef PS2_PARITY_CHECK_EN
    frame_ok = ~buffer_q[0] & dat_sync_q[1] & (^buffer_q[9:1]);
`else
    frame_ok = ~buffer_q[0] & dat_sync_q[1];
`endif
    accept = strobe && (cnt_q == 4'd10) && frame_ok;
    full   = (FIFO_AW'(w_ptr_q + 1'b1) == r_ptr_q);
    wr_en  = accept & ~full;
    pop    = ready_q & bus.read_next;

    if (strobe) begin
      if (cnt_q == 4'd10) begin
        cnt_d = 4'd0;
      end else begin
        buffer_d[cnt_q] = dat_sync_q[1];
        cnt_d           = cnt_q + 4'd1;
      end
    end

    w_ptr_d    = wr_en ? FIFO_AW'(w_ptr_q + 1'b1) : w_ptr_q;
    r_ptr_d    = pop   ? FIFO_AW'(r_ptr_q + 1'b1) : r_ptr_q;
    overflow_d = overflow_q | (accept & full);
    ready_d    = (w_ptr_d != r_ptr_d);
  end

  // Control and status registers with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_sync_q <= '0;
      dat_sync_q <= '0;
      cnt_q      <= '0;
      buffer_q   <= '0;
      w_ptr_q    <= '0;
      r_ptr_q    <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values, independent of statement order.
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      cnt_q      <= cnt_d;
      buffer_q   <= buffer_d;
      w_ptr_q    <= w_ptr_d;
      r_ptr_q    <= r_ptr_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage write port.
  // NOTE: storage is not reset; its contents are don't-care until ready says a slot holds valid data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_q[w_ptr_q] <= buffer_q[8:1];
    end
  end

  assign bus.ready    = ready_q;
  assign bus.overflow = overflow_q;
  assign bus.data     = fifo_q[r_ptr_q];

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: drives PS/2 frames into ps2_rx_fifo. Results are compared
// with a queue-based model of the receive FIFO.
module tb_ps2_rx_fifo;

  logic clk     = 1'b0;
  logic rstn    = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;

  ps2_rx_fifo_if bus ();

  ps2_rx_fifo #(.FIFO_AW(3)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .bus     (bus)
  );

  always #5 clk = ~clk;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int USABLE = 7;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] model_q [$];
  logic       model_ovf = 1'b0;

  // Monitor used by the read_next-tied-high scenario.
  bit         mon_en = 1'b0;
  int         ready_cycles = 0;
  logic [7:0] seen_data = '0;
  always @(negedge clk) begin
    if (mon_en && bus.ready === 1'b1) begin
      ready_cycles = ready_cycles + 1;
      seen_data    = bus.data;
    end
  end

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_start,
                                             input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f[0]   = bad_start;
    f[8:1] = b;
    f[9]   = ~(^b) ^ bad_par;
    f[10]  = ~bad_stop;
    return f;
  endfunction

  function automatic bit frame_valid(input logic [10:0] f);
    logic [8:0] dp;
    dp = f[9:1];
    return (f[0] == 1'b0) && (f[10] == 1'b1) && (!PAR_EN || (^dp) == 1'b1);
  endfunction

  task automatic model_push(input logic [7:0] b);
    if (model_q.size() == USABLE) model_ovf = 1'b1;
    else model_q.push_back(b);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = f[i];
      #100;
      ps2_clk = 1'b0;
      #200;
      ps2_clk = 1'b1;
      #100;
    end
  endtask

  task automatic send_frame(input logic [10:0] f);
    send_bits(f, 11);
    if (frame_valid(f)) model_push(f[8:1]);
    #200;
    @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk);
    bus.read_next = 1'b1;
    @(negedge clk);
    bus.read_next = 1'b0;
    if (model_q.size() != 0) void'(model_q.pop_front());
  endtask

  task automatic test_reset();
    bus.read_next = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    rstn = 1'b0;
    #23;
    vectors++;
    if (bus.ready !== 1'b0 || bus.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: ready=%b overflow=%b, required 0/0", bus.ready, bus.overflow);
    end
    model_q.delete();
    model_ovf = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
    if (bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_ready: ready=%b, required 0", bus.ready);
    end
  endtask

  task automatic test_single();
    send_frame(make_frame(8'h1C, 0, 0, 0));
    vectors++;
    if (bus.ready !== 1'b1 || bus.data !== 8'h1C) begin
      miscompares++;
      $display("FAIL single_rx: ready=%b data=%h, required 1/1c", bus.ready, bus.data);
    end
    repeat (10) @(negedge clk);
    vectors++;
    if (bus.ready !== 1'b1 || bus.data !== 8'h1C) begin
      miscompares++;
      $display("FAIL single_hold: ready=%b data=%h, required 1/1c", bus.ready, bus.data);
    end
    pop_one();
    vectors++;
    if (bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL single_pop: ready=%b, required 0", bus.ready);
    end
  endtask

  task automatic test_sequence();
    send_frame(make_frame(8'hF0, 0, 0, 0));
    send_frame(make_frame(8'h1C, 0, 0, 0));
    vectors++;
    if (bus.ready !== 1'b1 || bus.data !== 8'hF0) begin
      miscompares++;
      $display("FAIL seq_first: ready=%b data=%h, required 1/f0", bus.ready, bus.data);
    end
    pop_one();
    vectors++;
    if (bus.ready !== 1'b1 || bus.data !== 8'h1C) begin
      miscompares++;
      $display("FAIL seq_second: ready=%b data=%h, required 1/1c", bus.ready, bus.data);
    end
    pop_one();
    vectors++;
    if (bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_empty: ready=%b, required 0", bus.ready);
    end
  endtask

  task automatic test_bad_frames();
    logic [10:0] frames [3];
    frames[0] = make_frame(8'h1C, 0, 1, 0);
    frames[1] = make_frame(8'h1C, 0, 0, 1);
    frames[2] = make_frame(8'h1C, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      send_frame(frames[k]);
      vectors++;
      if (bus.ready !== (model_q.size() != 0)) begin
        miscompares++;
        $display("FAIL bad_frame_%0d: ready=%b, required %b", k, bus.ready, model_q.size() != 0);
      end
      if (model_q.size() != 0) begin
        vectors++;
        if (bus.data !== model_q[0]) begin
          miscompares++;
          $display("FAIL bad_frame_data_%0d: data=%h, required %h", k, bus.data, model_q[0]);
        end
        pop_one();
      end
    end
    send_frame(make_frame(8'h3A, 0, 0, 0));
    vectors++;
    if (bus.ready !== 1'b1 || bus.data !== 8'h3A) begin
      miscompares++;
      $display("FAIL resync_rx: ready=%b data=%h, required 1/3a", bus.ready, bus.data);
    end
    pop_one();
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 8; k++) begin
      send_frame(make_frame(8'(k), 0, 0, 0));
      vectors++;
      if (bus.overflow !== model_ovf) begin
        miscompares++;
        $display("FAIL ovf_after_%0d: overflow=%b, required %b", k, bus.overflow, model_ovf);
      end
    end
    for (int k = 1; k <= 7; k++) begin
      vectors++;
      if (bus.ready !== 1'b1 || bus.data !== 8'(k)) begin
        miscompares++;
        $display("FAIL ovf_pop_%0d: ready=%b data=%h, required 1/%h", k, bus.ready, bus.data, 8'(k));
      end
      pop_one();
    end
    vectors++;
    if (bus.ready !== 1'b0 || bus.overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_drained: ready=%b overflow=%b, required 0/1", bus.ready, bus.overflow);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(make_frame(8'h77, 0, 0, 0));
    send_bits(make_frame(8'hAB, 0, 0, 0), 5);
    #3;
    rstn = 1'b0;
    #1;
    vectors++;
    if (bus.ready !== 1'b0 || bus.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_reset: ready=%b overflow=%b, required 0/0", bus.ready, bus.overflow);
    end
    model_q.delete();
    model_ovf = 1'b0;
    #40;
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(make_frame(8'h5A, 0, 0, 0));
    vectors++;
    if (bus.ready !== 1'b1 || bus.data !== 8'h5A) begin
      miscompares++;
      $display("FAIL post_reset_rx: ready=%b data=%h, required 1/5a", bus.ready, bus.data);
    end
    pop_one();
  endtask

  task automatic test_tied_high();
    @(negedge clk);
    bus.read_next = 1'b1;
    ready_cycles  = 0;
    mon_en        = 1'b1;
    send_bits(make_frame(8'h1C, 0, 0, 0), 11);
    repeat (20) @(negedge clk);
    mon_en        = 1'b0;
    bus.read_next = 1'b0;
    vectors++;
    if (ready_cycles != 1 || seen_data !== 8'h1C) begin
      miscompares++;
      $display("FAIL tied_high: ready_cycles=%0d data=%h, required 1/1c", ready_cycles, seen_data);
    end
  endtask

  task automatic test_random();
    test_reset();
    for (int it = 0; it < 24; it++) begin
      logic [7:0] b;
      int kind, pops;
      b    = 8'($urandom);
      kind = $urandom_range(0, 5);
      send_frame(make_frame(b, kind == 0, kind == 1, kind == 2));
      vectors++;
      if (bus.ready !== (model_q.size() != 0) || bus.overflow !== model_ovf) begin
        miscompares++;
        $display("FAIL rand_state_%0d: ready=%b overflow=%b, required %b/%b",
                 it, bus.ready, bus.overflow, model_q.size() != 0, model_ovf);
      end
      pops = $urandom_range(0, 2);
      for (int p = 0; p < pops; p++) begin
        if (model_q.size() != 0) begin
          vectors++;
          if (bus.data !== model_q[0]) begin
            miscompares++;
            $display("FAIL rand_data_%0d: data=%h, required %h", it, bus.data, model_q[0]);
          end
        end
        pop_one();
        vectors++;
        if (bus.ready !== (model_q.size() != 0)) begin
          miscompares++;
          $display("FAIL rand_pop_%0d: ready=%b, required %b", it, bus.ready, model_q.size() != 0);
        end
      end
    end
  endtask

  initial begin
    bus.read_next = 1'b0;
    test_reset();
    test_single();
    test_sequence();
    test_bad_frames();
    test_overflow();
    test_reset_mid_frame();
    test_tied_high();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
